// File: rtl/psram_ctrl_pkg.sv
// Shared types and constants for the PSRAM HS request sequencer.
// Widths follow the Gowin PSRAM HS IP user interface.
package psram_ctrl_pkg;

  localparam int ADDR_W          = 21;
  localparam int DATA_W          = 64;
  localparam int DEF_BURST_BEATS = 4;
  localparam int DEF_CMD_GAP     = 14;
  localparam int DEF_RD_TIMEOUT  = 255;

  typedef enum logic [2:0] {
    ST_WAIT_CALIB = 3'd0,
    ST_IDLE       = 3'd1,
    ST_WR_CMD     = 3'd2,
    ST_WR_BURST   = 3'd3,
    ST_RD_CMD     = 3'd4,
    ST_RD_WAIT    = 3'd5,
    ST_RD_BURST   = 3'd6,
    ST_GAP        = 3'd7
  } psram_ctrl_state_t;

endpackage

// File: rtl/psram_req_ctrl.sv
// Sequences user read/write requests into timed PSRAM HS IP commands and bursts,
// enforcing the inter-command gap and supervising read completion.
module psram_req_ctrl
  import psram_ctrl_pkg::*;
#(
  parameter int BURST_BEATS = DEF_BURST_BEATS,
  parameter int CMD_GAP     = DEF_CMD_GAP,
  parameter int RD_TIMEOUT  = DEF_RD_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_rd,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              rdata_last,
  output logic              err,
  output logic              cmd,
  output logic              cmd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_valid
);

  localparam int BEAT_W = $clog2(BURST_BEATS);
  localparam int GAP_W  = $clog2(CMD_GAP + 1);
  localparam int TO_W   = $clog2(RD_TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CMD_GAP - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RD_TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

  psram_ctrl_state_t state_r, state_nxt_s;
  logic [BEAT_W-1:0] beat_r, beat_nxt_s;
  logic [GAP_W-1:0]  gap_r, gap_nxt_s;
  logic [TO_W-1:0]   to_r, to_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] rdata_r;
  logic              rdata_valid_r, rdata_last_r, err_r;
  logic              accept_s, cap_s, last_s, err_s;

  assign accept_s = req_valid & req_ready;

  // Next-state, counter and read-capture decisions
  always_comb begin
    state_nxt_s = state_r;
    beat_nxt_s  = beat_r;
    gap_nxt_s   = gap_r;
    to_nxt_s    = to_r;
    cap_s       = 1'b0;
    last_s      = 1'b0;
    err_s       = 1'b0;
    if (!init_calib) begin
      // Losing calibration abandons any in-flight transfer.
      state_nxt_s = ST_WAIT_CALIB;
      err_s = (state_r != ST_WAIT_CALIB) && (state_r != ST_IDLE) && (state_r != ST_GAP);
    end else begin
      case (state_r)
        ST_WAIT_CALIB: state_nxt_s = ST_IDLE;
        ST_IDLE: begin
          if (accept_s) begin
            state_nxt_s = req_write ? ST_WR_CMD : ST_RD_CMD;
            beat_nxt_s  = '0;
            to_nxt_s    = '0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_WR_CMD: begin
          beat_nxt_s  = beat_r + BEAT_ONE;
          state_nxt_s = ST_WR_BURST;
        end
        ST_WR_BURST: begin
          if (beat_r == BEAT_LAST) begin
            state_nxt_s = ST_GAP;
            gap_nxt_s   = '0;
          end else begin
            beat_nxt_s = beat_r + BEAT_ONE;
          end
        end
        ST_RD_CMD: state_nxt_s = ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (rd_data_valid) begin
            cap_s       = 1'b1;
            beat_nxt_s  = beat_r + BEAT_ONE;
            state_nxt_s = ST_RD_BURST;
          end else if (to_r == TO_LAST) begin
            err_s       = 1'b1;
            state_nxt_s = ST_GAP;
            gap_nxt_s   = '0;
          end else begin
            to_nxt_s = to_r + TO_ONE;
          end
        end
        ST_RD_BURST: begin
          if (rd_data_valid) begin
            cap_s = 1'b1;
            if (beat_r == BEAT_LAST) begin
              last_s      = 1'b1;
              state_nxt_s = ST_GAP;
              gap_nxt_s   = '0;
            end else begin
              beat_nxt_s = beat_r + BEAT_ONE;
            end
          end else begin
            err_s       = 1'b1;
            state_nxt_s = ST_GAP;
            gap_nxt_s   = '0;
          end
        end
        ST_GAP: begin
          if (gap_r == GAP_LAST) begin
            state_nxt_s = ST_IDLE;
          end else begin
            gap_nxt_s = gap_r + GAP_ONE;
          end
        end
        default: state_nxt_s = ST_WAIT_CALIB;
      endcase
    end
  end

  // State, counters, latched address and registered read-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_WAIT_CALIB;
      beat_r        <= '0;
      gap_r         <= '0;
      to_r          <= '0;
      addr_r        <= '0;
      rdata_r       <= '0;
      rdata_valid_r <= 1'b0;
      rdata_last_r  <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      beat_r        <= beat_nxt_s;
      gap_r         <= gap_nxt_s;
      to_r          <= to_nxt_s;
      rdata_valid_r <= cap_s;
      rdata_last_r  <= last_s;
      err_r         <= err_s;
      if (accept_s) begin
        addr_r <= req_addr;
      end
      if (cap_s) begin
        rdata_r <= rd_data;
      end
    end
  end

  // IP-facing strobes decoded from the registered state
  always_comb begin
    req_ready = (state_r == ST_IDLE) && init_calib;
    cmd_en    = (state_r == ST_WR_CMD) || (state_r == ST_RD_CMD);
    cmd       = (state_r == ST_WR_CMD);
    wdata_rd  = (state_r == ST_WR_CMD) || (state_r == ST_WR_BURST);
    if (wdata_rd) begin
      wr_data = wdata;
    end else begin
      wr_data = '0;
    end
  end

  assign addr        = addr_r;
  assign rdata       = rdata_r;
  assign rdata_valid = rdata_valid_r;
  assign rdata_last  = rdata_last_r;
  assign err         = err_r;

endmodule
